uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter: MAX_STALL, default 64, idle cycles tolerated from the granted requester before forced release.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: req_valid  in  NUM_REQ  per-requester byte valid.
REQ-006 Port: req_data  in  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 Port: req_last  in  NUM_REQ  marks the final byte of requester's packet.
REQ-008 Port: req_ready  out  NUM_REQ  byte accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 Port: fifo_full  in  1  UART TX FIFO full flag.
REQ-010 Port: fifo_wr  out  1  UART TX FIFO write enable.
REQ-011 Port: fifo_data  out  8  UART TX FIFO write data.
REQ-012 Port: grant_id  out  $clog2(NUM_REQ)  index of current owner; holds last owner when IDLE.
REQ-013 Port: busy  out  1  high while in GRANT state.
REQ-014 Port: stall_timeout  out  1  one-cycle pulse on forced release.

Function
REQ-015 The FSM SHALL have two states: IDLE (no owner) and GRANT (one requester owns the FIFO write port).
REQ-016 In IDLE with any req_valid high, the block SHALL pick the winner round-robin, searching from last_grant+1 upward with wrap, register grant_id, and enter GRANT on the next edge.
REQ-017 In IDLE with no req_valid, the state SHALL stay IDLE; all req_ready and fifo_wr SHALL be 0.
REQ-018 In GRANT, req_ready[grant_id] SHALL equal !fifo_full (combinational); all other req_ready bits SHALL be 0.
REQ-019 In GRANT, fifo_wr SHALL equal req_valid[grant_id] & !fifo_full & !reset, and fifo_data SHALL equal req_data of grant_id, with zero-cycle latency.
REQ-020 A transfer with req_last[grant_id] high SHALL end the packet: last_grant <= grant_id, state -> IDLE; packets are therefore separated by exactly one idle cycle.
REQ-021 Ownership SHALL persist across fifo_full stalls for any length; non-owner requests are ignored until release.
REQ-022 stall_cnt SHALL count GRANT cycles with req_valid[grant_id]=0 and fifo_full=0; it SHALL clear on any transfer and on entering GRANT.
REQ-023 When stall_cnt reaches MAX_STALL-1 and the owner is still idle, the block SHALL release (state -> IDLE, last_grant <= grant_id) and pulse stall_timeout for that cycle.
REQ-024 If req_valid and req_last arrive on the same cycle that timeout would fire, the transfer SHALL win: byte written, no timeout pulse.
REQ-025 A request seen in IDLE and withdrawn before GRANT SHALL still be granted; the owner then falls under the stall timeout.
REQ-026 Timing: first req_valid in IDLE at cycle n -> earliest fifo_wr at cycle n+1.

Reset
REQ-027 When reset is high at a clock edge, the state SHALL become IDLE, grant_id 0, last_grant NUM_REQ-1 (requester 0 has first priority), and stall_cnt 0.
REQ-028 While reset is high, fifo_wr, req_ready, busy and stall_timeout SHALL be 0; a packet in flight is abandoned without further writes.

Structure
REQ-029 definitions_pkg SHALL hold the arb_state_t enum (IDLE, GRANT) and UART_DATA_W = 8; uart_tx_arbiter SHALL import it.
REQ-030 Round-robin selection SHALL be one combinational sub-module, rr_pick (inputs: request vector and last_grant; outputs: winner index and any-valid).
REQ-031 The arbiter SHALL drive only the UART TX FIFO write side and SHALL NOT touch the baud generator, transmitter or RX path.

Verification
REQ-032 Single requester: req 2 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) -> fifo_wr for 3 consecutive cycles from n+1, data in order, busy falls after 0x43.
REQ-033 All 4 requesters hold one-byte packets continuously after reset -> grant order 0,1,2,3,0; one idle cycle between each grant.
REQ-034 fifo_full held high for 20 cycles mid-packet -> req_ready 0, no writes, no timeout, ownership kept; writes resume the cycle after fifo_full falls.
REQ-035 Owner 1 drops req_valid mid-packet with MAX_STALL=64 -> stall_timeout pulses once after 64 idle cycles; next grant goes to requester 2 if it is requesting.
REQ-036 Reset asserted during a 5-byte packet after byte 2 -> fifo_wr 0 that cycle; state IDLE; next grant goes to requester 0.

Source files
------------

// File: rtl/definitions_pkg.sv
// Shared definitions for the UART TX arbiter slice.
//   arb_state_t : arbiter FSM encoding (IDLE = no owner, GRANT = one owner)
//   UART_DATA_W : width of one UART byte lane
package definitions_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int UART_DATA_W = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters / UART TX FIFO write side and the arbiter.
//   master : requester + FIFO side (drives byte streams and fifo_full)
//   slave  : arbiter side (drives ready, FIFO write, status)
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import definitions_pkg::*;

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*UART_DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           fifo_full;
  logic                           fifo_wr;
  logic [UART_DATA_W-1:0]         fifo_data;
  logic [ID_W-1:0]                grant_id;
  logic                           busy;
  logic                           stall_timeout;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr, fifo_data, grant_id, busy, stall_timeout
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr, fifo_data, grant_id, busy, stall_timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector
//   last_grant : index granted most recently; search starts at last_grant+1
//   winner     : first requesting index found, wrapping past NUM_REQ-1
//   any_valid  : at least one request present
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  logic        found;
  int unsigned idx;

  always_comb begin
    winner    = '0;
    found     = 1'b0;
    idx       = 0;
    any_valid = |req;
    // Offsets 1..NUM_REQ so last_grant itself is considered last.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one requester at a time the UART TX FIFO
// write port for a whole packet (ended by req_last), with a stall timeout
// that releases an owner that stops sending.
//   clk, reset : clock, synchronous active-high reset
//   bus        : requester byte streams, FIFO write side and status
module uart_tx_arbiter
  import definitions_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_STALL = 64
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STALL_W = (MAX_STALL > 1) ? $clog2(MAX_STALL) : 1;
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(MAX_STALL - 1);

  arb_state_t         state_q, state_n;
  logic [ID_W-1:0]    grant_q, grant_n;
  logic [ID_W-1:0]    last_q, last_n;
  logic [STALL_W-1:0] stall_q, stall_n;

  logic [ID_W-1:0]    winner;
  logic               any_valid;
  logic               owner_valid;
  logic               owner_last;
  logic               xfer;
  logic               owner_idle;
  logic               timeout;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req        (bus.req_valid),
    .last_grant (last_q),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  always_comb begin
    owner_valid = bus.req_valid[grant_q];
    owner_last  = bus.req_last[grant_q];
    xfer        = (state_q == GRANT) && owner_valid && !bus.fifo_full;
    owner_idle  = (state_q == GRANT) && !owner_valid && !bus.fifo_full;
    // A transfer on the limit cycle is excluded by owner_idle, so it wins.
    timeout     = owner_idle && (stall_q == STALL_LIM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      stall_q <= '0;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      last_q  <= last_n;
      stall_q <= stall_n;
    end
  end

  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    last_n  = last_q;
    stall_n = stall_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_n = GRANT;
          grant_n = winner;
          stall_n = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          stall_n = '0;
          if (owner_last) begin
            state_n = IDLE;
            last_n  = grant_q;
          end
        end else if (timeout) begin
          state_n = IDLE;
          last_n  = grant_q;
          stall_n = '0;
        end else if (owner_idle) begin
          stall_n = stall_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready     = '0;
    bus.fifo_wr       = 1'b0;
    bus.busy          = 1'b0;
    bus.stall_timeout = 1'b0;
    bus.grant_id      = grant_q;
    bus.fifo_data     = bus.req_data[UART_DATA_W*int'(grant_q) +: UART_DATA_W];
    if (!reset && (state_q == GRANT)) begin
      bus.req_ready[grant_q] = !bus.fifo_full;
      bus.fifo_wr            = xfer;
      bus.busy               = 1'b1;
      bus.stall_timeout      = timeout;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ   (4),
    .MAX_STALL (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    bus.req_valid[i]     = v;
    bus.req_data[i*8 +: 8] = d;
    bus.req_last[i]      = l;
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.id   = id[1:0];
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Owner idle for n cycles from stall count 0: pulse only on the last one.
  task automatic watch_stall(input int n, input logic [3:0] rdy, input int gid);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      chk("stall_timeout", 32'(bus.stall_timeout), 32'(j == n - 1));
      chk("stall_busy", 32'(bus.busy), 32'd1);
      chk("stall_wr", 32'(bus.fifo_wr), 32'd0);
      chk("stall_ready", 32'(bus.req_ready), 32'(rdy));
      chk("stall_grant", 32'(bus.grant_id), 32'(gid));
      tick();
    end
  endtask

  // Scoreboard: every FIFO write pops the oldest expected byte.
  always @(negedge clk) begin
    if (bus.fifo_wr === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_wr observed=0x%0h expected=no_write", bus.fifo_data);
      end
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_data", 32'(bus.fifo_data), 32'(e.data));
        chk("wr_grant", 32'(bus.grant_id), 32'(e.id));
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wr", 32'(bus.fifo_wr), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_timeout", 32'(bus.stall_timeout), 32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Single requester 2, three bytes
    set_req(2, 1'b1, 8'h41, 1'b0);
    push(2, 8'h41);
    @(negedge clk);
    chk("s1_first_wr_latency", 32'(bus.fifo_wr), 32'd0);
    chk("s1_idle_busy", 32'(bus.busy), 32'd0);
    tick();
    @(negedge clk);
    chk("s1_wr0", 32'(bus.fifo_wr), 32'd1);
    chk("s1_ready", 32'(bus.req_ready), 32'h4);
    tick();
    set_req(2, 1'b1, 8'h42, 1'b0);
    push(2, 8'h42);
    @(negedge clk);
    chk("s1_wr1", 32'(bus.fifo_wr), 32'd1);
    tick();
    set_req(2, 1'b1, 8'h43, 1'b1);
    push(2, 8'h43);
    @(negedge clk);
    chk("s1_wr2", 32'(bus.fifo_wr), 32'd1);
    tick();
    set_req(2, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("s1_busy_after", 32'(bus.busy), 32'd0);
    tick();

    // All four requesters with continuous one-byte packets after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'hA0 + 8'(i), 1'b1);
    for (int k = 0; k < 5; k++) push(k % 4, 8'hA0 + 8'(k % 4));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rr_busy", 32'(bus.busy), 32'(k % 2));
      chk("rr_wr", 32'(bus.fifo_wr), 32'(k % 2));
      if (k % 2 == 1) chk("rr_grant", 32'(bus.grant_id), 32'(((k - 1) / 2) % 4));
      tick();
    end
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("rr_idle", 32'(bus.busy), 32'd0);
    tick();

    // fifo_full stall of 20 cycles mid-packet, non-owner requesting meanwhile
    set_req(1, 1'b1, 8'h10, 1'b0);
    push(1, 8'h10);
    tick();
    @(negedge clk);
    chk("ff_grant", 32'(bus.grant_id), 32'd1);
    tick();
    set_req(1, 1'b1, 8'h11, 1'b0);
    push(1, 8'h11);
    tick();
    set_req(1, 1'b1, 8'h12, 1'b0);
    push(1, 8'h12);
    set_req(3, 1'b1, 8'h33, 1'b1);
    bus.fifo_full = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk("ff_wr", 32'(bus.fifo_wr), 32'd0);
      chk("ff_ready", 32'(bus.req_ready), 32'd0);
      chk("ff_busy", 32'(bus.busy), 32'd1);
      chk("ff_owner", 32'(bus.grant_id), 32'd1);
      chk("ff_timeout", 32'(bus.stall_timeout), 32'd0);
      tick();
    end
    bus.fifo_full = 1'b0;
    @(negedge clk);
    chk("ff_resume", 32'(bus.fifo_wr), 32'd1);
    tick();
    set_req(1, 1'b1, 8'h13, 1'b1);
    push(1, 8'h13);
    push(3, 8'h33);
    @(negedge clk);
    chk("ff_last", 32'(bus.fifo_wr), 32'd1);
    tick();
    set_req(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("ff_gap", 32'(bus.busy), 32'd0);
    tick();
    @(negedge clk);
    chk("ff_next_grant", 32'(bus.grant_id), 32'd3);
    tick();
    set_req(3, 1'b0, 8'h00, 1'b0);

    // Owner 1 goes silent mid-packet; requester 2 waiting
    set_req(1, 1'b1, 8'h51, 1'b0);
    push(1, 8'h51);
    tick();
    @(negedge clk);
    chk("to_grant", 32'(bus.grant_id), 32'd1);
    tick();
    set_req(1, 1'b0, 8'h00, 1'b0);
    set_req(2, 1'b1, 8'h62, 1'b1);
    push(2, 8'h62);
    watch_stall(64, 4'b0010, 1);
    @(negedge clk);
    chk("to_released", 32'(bus.busy), 32'd0);
    chk("to_single_pulse", 32'(bus.stall_timeout), 32'd0);
    tick();
    @(negedge clk);
    chk("to_next_grant", 32'(bus.grant_id), 32'd2);
    tick();
    set_req(2, 1'b0, 8'h00, 1'b0);

    // Last byte lands on the timeout cycle: the transfer wins
    set_req(3, 1'b1, 8'h70, 1'b0);
    push(3, 8'h70);
    tick();
    tick();
    set_req(3, 1'b0, 8'h00, 1'b0);
    for (int j = 0; j < 63; j++) begin
      @(negedge clk);
      chk("race_no_timeout", 32'(bus.stall_timeout), 32'd0);
      tick();
    end
    set_req(3, 1'b1, 8'h71, 1'b1);
    push(3, 8'h71);
    @(negedge clk);
    chk("race_timeout", 32'(bus.stall_timeout), 32'd0);
    chk("race_wr", 32'(bus.fifo_wr), 32'd1);
    tick();
    set_req(3, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("race_idle", 32'(bus.busy), 32'd0);
    tick();

    // Request withdrawn while IDLE is still granted, then times out
    set_req(0, 1'b1, 8'hAA, 1'b1);
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    watch_stall(64, 4'b0001, 0);
    @(negedge clk);
    chk("wd_released", 32'(bus.busy), 32'd0);
    tick();

    // Reset during a 5-byte packet from requester 2 after byte 2
    set_req(2, 1'b1, 8'h81, 1'b0);
    push(2, 8'h81);
    tick();
    tick();
    set_req(2, 1'b1, 8'h82, 1'b0);
    push(2, 8'h82);
    @(negedge clk);
    chk("mr_wr2", 32'(bus.fifo_wr), 32'd1);
    tick();
    set_req(2, 1'b1, 8'h83, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_wr_in_reset", 32'(bus.fifo_wr), 32'd0);
    chk("mr_busy_in_reset", 32'(bus.busy), 32'd0);
    chk("mr_ready_in_reset", 32'(bus.req_ready), 32'd0);
    chk("mr_timeout_in_reset", 32'(bus.stall_timeout), 32'd0);
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, 8'h90, 1'b1);
    push(0, 8'h90);
    @(negedge clk);
    chk("mr_idle", 32'(bus.busy), 32'd0);
    tick();
    @(negedge clk);
    chk("mr_next_grant", 32'(bus.grant_id), 32'd0);
    chk("mr_wr", 32'(bus.fifo_wr), 32'd1);
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(2, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("mr_end_idle", 32'(bus.busy), 32'd0);
    tick();
    tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
